// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   DATA_W, DEPTH, IDX_W : data/address width, memory depth, word-index width
//   size_e               : access size encoding (byte/half/word/dword)
//   state_e              : load/store FSM states
//   size_bytes()         : access size in bytes
package lsu_pkg;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 64;
  localparam int IDX_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HALF  = 2'b01,
    WORD  = 2'b10,
    DWORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  function automatic logic [3:0] size_bytes(input size_e s);
    return 4'd1 << s;
  endfunction
endpackage

// File: rtl/lsu_lane_unit.sv
// lsu_lane_unit: combinational byte-lane extract/extend and store merge.
// Ports:
//   word      in  memory word being read
//   off       in  byte offset of the access within the word
//   size      in  access size
//   is_signed in  sign-extend the extracted value (sub-dword only)
//   wdata     in  store data, low bytes used
//   load_data out extracted and extended load value
//   merged    out word with the store lanes replaced, other bytes kept
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        off,
  input  size_e             size,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);

  logic [5:0]        sh;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lane_mask;

  assign sh = {off, 3'b000};

  always_comb begin
    shifted   = word >> sh;
    load_data = shifted;
    lane_mask = '1;
    case (size)
      BYTE: begin
        load_data = {{56{is_signed & shifted[7]}}, shifted[7:0]};
        lane_mask = 64'h0000_0000_0000_00FF;
      end
      HALF: begin
        load_data = {{48{is_signed & shifted[15]}}, shifted[15:0]};
        lane_mask = 64'h0000_0000_0000_FFFF;
      end
      WORD: begin
        load_data = {{32{is_signed & shifted[31]}}, shifted[31:0]};
        lane_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        load_data = shifted;
        lane_mask = '1;
      end
    endcase
    merged = (word & ~(lane_mask << sh)) | ((wdata & lane_mask) << sh);
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage translating byte-addressed 1/2/4/8-byte
// loads and stores into word-indexed accesses on a 64 x 64-bit memory.
// Sub-dword stores are read-modify-write. Optional LSU_FAULT_EN macro enables
// range/alignment fault reporting; without it addresses are force-aligned and
// wrap modulo DEPTH, and resp_fault is tied low.
// Ports:
//   clk, rst (async, active low)
//   req_valid/req_ready, req_write, req_size, req_signed, req_addr, req_wdata
//   resp_valid/resp_ready, resp_rdata, resp_fault
//   mem_addr (word index), mem_wdata, mem_re, mem_we, mem_rdata (comb. read)
//
// state | meaning
// IDLE  | ready; captures request on req_valid
// READ  | mem_re; latch load result or merged store word
// WRITE | mem_we; merged (or full dword) word committed at end of cycle
// RESP  | resp_valid held until resp_ready
module load_store_unit
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state;
  logic              write_q;
  size_e             size_q;
  logic              signed_q;
  logic [2:0]        off_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              fault_q;
  logic [DATA_W-1:0] mwdata_q;

  size_e             req_sz;
  logic [2:0]        req_off;
  logic [2:0]        align_mask;
  logic [2:0]        off_eff;
  logic              fault;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  assign req_sz  = size_e'(req_size);
  assign req_off = req_addr[2:0];
  // bytes-1 truncated to 3 bits gives the low-address mask that must be zero
  assign align_mask = 3'(size_bytes(req_sz) - 4'd1);

`ifdef LSU_FAULT_EN
  assign fault   = (|req_addr[DATA_W-1:IDX_W+3]) | (|(req_off & align_mask));
  assign off_eff = req_off;
`else
  logic unused_hi;
  assign unused_hi = ^req_addr[DATA_W-1:IDX_W+3];
  assign fault     = 1'b0;
  assign off_eff   = req_off & ~align_mask;
`endif

  lsu_lane_unit u_lane (
    .word      (mem_rdata),
    .off       (off_q),
    .size      (size_q),
    .is_signed (signed_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      size_q   <= BYTE;
      signed_q <= 1'b0;
      off_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
      mwdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            size_q   <= req_sz;
            signed_q <= req_signed;
            off_q    <= off_eff;
            idx_q    <= req_addr[IDX_W+2:3];
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            fault_q  <= fault;
            if (fault) begin
              state <= RESP;
            end else if (req_write && req_sz == DWORD) begin
              mwdata_q <= req_wdata;
              state    <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (write_q) begin
            mwdata_q <= merged;
            state    <= WRITE;
          end else begin
            rdata_q <= load_data;
            state   <= RESP;
          end
        end
        WRITE: state <= RESP;
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode from the state register only, so reset drops them at once.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_re     = (state == READ);
  assign mem_we     = (state == WRITE);
  assign mem_addr   = {{(DATA_W-IDX_W){1'b0}}, idx_q};
  assign mem_wdata  = mwdata_q;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus randomized stimulus for load_store_unit,
// checked against a byte-level reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [63:0] mem_rdata;

  logic [63:0] mem [64];
  logic [63:0] ref_mem [64];
  logic        preload = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 64'(i);
    end else if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: byte-lane arithmetic on a shadow memory.
  function automatic void model(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [63:0] addr, input logic [63:0] wd,
                                output logic f, output logic [63:0] rd, output int idx,
                                output int lat, output int nre, output int nwe,
                                output logic [63:0] wword);
    int nb;
    int off;
    nb  = 1 << sz;
    off = int'(addr[2:0]);
    idx = int'(addr[8:3]);
`ifdef LSU_FAULT_EN
    f = ((addr >> 9) != 0) || ((off % nb) != 0);
`else
    f = 1'b0;
    off = off - (off % nb);
`endif
    rd = '0; wword = '0; nre = 0; nwe = 0; lat = 1;
    if (f) begin
      lat = 1;
    end else if (!w) begin
      for (int b = 0; b < nb; b++) rd[8*b +: 8] = ref_mem[idx][8*(off+b) +: 8];
      if (sg && nb < 8 && rd[8*nb-1])
        for (int b = nb; b < 8; b++) rd[8*b +: 8] = 8'hFF;
      lat = 2; nre = 1;
    end else begin
      wword = ref_mem[idx];
      for (int b = 0; b < nb; b++) wword[8*(off+b) +: 8] = wd[8*b +: 8];
      ref_mem[idx] = wword;
      lat = (nb == 8) ? 2 : 3;
      nre = (nb == 8) ? 0 : 1;
      nwe = 1;
    end
  endfunction

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [63:0] addr, input logic [63:0] wd, input int hold);
    logic        f;
    logic [63:0] rd;
    logic [63:0] ww;
    int          idx, lat, nre, nwe, cyc;
    int          re_cnt, we_cnt;
    logic        both, addr_ok;
    logic [63:0] seen_wdata;
    re_cnt = 0; we_cnt = 0; both = 1'b0; addr_ok = 1'b1; seen_wdata = '0;
    model(w, sz, sg, addr, wd, f, rd, idx, lat, nre, nwe, ww);
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      if (mem_re) re_cnt++;
      if (mem_we) begin
        we_cnt++;
        seen_wdata = mem_wdata;
      end
      if (mem_re && mem_we) both = 1'b1;
      if ((mem_re || mem_we) && mem_addr !== 64'(idx)) addr_ok = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    check("resp_valid", resp_valid, 1'b1);
    check("latency", 64'(cyc), 64'(lat));
    check("rdata", resp_rdata, rd);
    check("fault", resp_fault, f);
    check("re_count", 64'(re_cnt), 64'(nre));
    check("we_count", 64'(we_cnt), 64'(nwe));
    check("strobe_exclusive", both, 1'b0);
    check("strobe_addr", addr_ok, 1'b1);
    if (nwe != 0) check("mem_wdata", seen_wdata, ww);
    for (int i = 0; i < hold; i++) begin
      // A request presented while busy must be ignored.
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b11; req_addr = 64'h8;
      @(posedge clk); #1;
      check("hold_valid", resp_valid, 1'b1);
      check("hold_rdata", resp_rdata, rd);
      check("hold_fault", resp_fault, f);
      check("hold_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("back_idle", req_ready, 1'b1);
    check("resp_dropped", resp_valid, 1'b0);
  endtask

  initial begin
    int          r;
    int          nb;
    logic [1:0]  sz;
    logic [63:0] addr;
    for (int i = 0; i < 64; i++) ref_mem[i] = 64'(i);

    preload = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 64'h0);
    check("rst_resp_fault", resp_fault, 1'b0);
    check("rst_mem_re", mem_re, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    preload = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed steps
    do_req(1'b0, 2'b11, 1'b0, 64'h18, 64'h0, 0);
    do_req(1'b1, 2'b00, 1'b0, 64'h21, 64'hAB, 0);
    do_req(1'b0, 2'b11, 1'b0, 64'h20, 64'h0, 0);
    do_req(1'b1, 2'b10, 1'b0, 64'h28, 64'h8000_00F0, 0);
    do_req(1'b0, 2'b10, 1'b1, 64'h28, 64'h0, 0);
    do_req(1'b0, 2'b10, 1'b0, 64'h28, 64'h0, 0);
    do_req(1'b0, 2'b01, 1'b0, 64'h13, 64'h0, 0);
    do_req(1'b0, 2'b00, 1'b0, 64'h200, 64'h0, 0);
    do_req(1'b0, 2'b11, 1'b0, 64'h20, 64'h0, 5);
    do_req(1'b0, 2'b00, 1'b1, 64'h21, 64'h0, 0);

    // Reset during WRITE of a byte store
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 64'h30; req_wdata = 64'hCD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstmid_in_write", mem_we, 1'b1);
    rst = 1'b0;
    #1;
    check("rstmid_we_drop", mem_we, 1'b0);
    check("rstmid_resp_valid", resp_valid, 1'b0);
    check("rstmid_req_ready", req_ready, 1'b1);
    check("rstmid_mem_addr", mem_addr, 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_after_ready", req_ready, 1'b1);
    check("rstmid_after_valid", resp_valid, 1'b0);
    ref_mem[6] = mem[6];

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      sz = 2'($urandom_range(0, 3));
      nb = 1 << sz;
      r  = $urandom_range(0, 9);
      if (r < 7) begin
        addr = {55'h0, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7) & ~(nb - 1))};
      end else if (r == 7) begin
        addr = {55'h0, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7))};
      end else begin
        addr = {$urandom, $urandom};
        addr[63:60] = 4'($urandom_range(1, 15));
      end
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
             {$urandom, $urandom}, (n % 37 == 0) ? 2 : 0);
    end

    for (int i = 0; i < 64; i++) check("mem_final", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
